// File: rtl/ins_mem_pkg.sv
// Shared definitions for the instruction memory loader: FSM states and
// memory geometry.
package ins_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    localparam int BYTES_PER_WORD    = 4;
    localparam int MEM_BYTES_DEFAULT = 240;

endpackage

// File: rtl/ins_mem_loader_word_assembler.sv
// Packs an 8-bit stream into big-endian 32-bit words. The first three bytes
// are kept; the fourth is merged in directly so the word is ready on the
// cycle that byte is accepted.
module word_assembler
    import ins_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        shift_en,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last_byte
);

    logic [23:0] shift_q;
    logic [1:0]  byte_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_q  <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            shift_q  <= {shift_q[15:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word      = {shift_q, byte_in};
    assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/ins_mem_loader.sv
// Loads a byte stream into the instruction RAM as big-endian words while
// holding the CPU through Busy.
module ins_mem_loader
    import ins_mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [31:0]      BaseAddr,
    input  logic [CNT_W-1:0] WordCount,
    input  logic [7:0]       ByteIn,
    input  logic             ByteValid,
    output logic             ByteReady,
    output logic             WrEn,
    output logic [31:0]      WrAddr,
    output logic [31:0]      WrData,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    state_t           state, state_next;
    logic [31:0]      cur_addr;
    logic [CNT_W-1:0] remaining;
    logic [31:0]      asm_word;
    logic             last_byte;
    logic             transfer;
    logic             addr_load;
    logic             clear_asm;
    logic             wr_capture;
    logic             err_next;
    logic             misaligned;
    logic             too_big;
    logic [33:0]      end_addr;

    // End address is formed wide enough that a huge WordCount cannot wrap.
    assign end_addr   = {2'b00, BaseAddr} + 34'({WordCount, 2'b00});
    assign misaligned = (BaseAddr[1:0] != 2'b00);
    assign too_big    = (end_addr > 34'(MEM_BYTES));
    assign transfer   = (state == COLLECT) && ByteValid && ByteReady;

    word_assembler u_word_assembler (
        .clk       (CLK),
        .reset     (Reset),
        .shift_en  (transfer),
        .clear     (clear_asm),
        .byte_in   (ByteIn),
        .word      (asm_word),
        .last_byte (last_byte)
    );

    always_comb begin
        state_next = state;
        addr_load  = 1'b0;
        clear_asm  = 1'b0;
        wr_capture = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (misaligned || too_big) begin
                        err_next = 1'b1;
                    end else if (WordCount == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = COLLECT;
                        addr_load  = 1'b1;
                        clear_asm  = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (transfer && last_byte) begin
                    state_next = WRITE;
                    wr_capture = 1'b1;
                end
            end
            WRITE: begin
                state_next = (remaining == CNT_W'(1)) ? DONE : COLLECT;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            ByteReady <= 1'b0;
            WrEn      <= 1'b0;
            WrAddr    <= '0;
            WrData    <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            state     <= state_next;
            ByteReady <= (state_next == COLLECT);
            WrEn      <= (state_next == WRITE);
            Busy      <= (state_next != IDLE);
            Done      <= (state_next == DONE);
            Err       <= err_next;
            if (addr_load) begin
                cur_addr  <= BaseAddr;
                remaining <= WordCount;
            end else if (state == WRITE) begin
                cur_addr  <= cur_addr + 32'd4;
                remaining <= remaining - CNT_W'(1);
            end
            if (wr_capture) begin
                WrAddr <= cur_addr;
                WrData <= asm_word;
            end
        end
    end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Scoreboard bench for ins_mem_loader: a session model queues expected
// writes/completions and a negedge monitor checks what the loader emits.
module tb_ins_mem_loader;

    localparam int MEM_BYTES = 240;
    localparam int CNT_W     = 16;

    typedef enum int {EV_WRITE, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          words;
    } ev_t;

    logic             CLK;
    logic             Reset;
    logic             Start;
    logic [31:0]      BaseAddr;
    logic [CNT_W-1:0] WordCount;
    logic [7:0]       ByteIn;
    logic             ByteValid;
    logic             ByteReady;
    logic             WrEn;
    logic [31:0]      WrAddr;
    logic [31:0]      WrData;
    logic             Busy;
    logic             Done;
    logic             Err;

    ev_t        exp_q[$];
    logic [7:0] stim_bytes[$];
    int         compared;
    int         mismatched;
    int         cyc;
    int         last_wr_cyc;
    int         prev_wr_cyc;
    int         ends_seen;

    ins_mem_loader #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Start     (Start),
        .BaseAddr  (BaseAddr),
        .WordCount (WordCount),
        .ByteIn    (ByteIn),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: a session either is rejected, or writes every group of four
    // stream bytes big-endian at consecutive word addresses and then completes.
    task automatic modelSession(input logic [31:0] base, input int wc);
        ev_t e;
        if ((base % 4) != 0 || longint'(base) + 4 * longint'(wc) > MEM_BYTES) begin
            e.kind = EV_ERR; e.addr = 0; e.data = 0; e.words = 0;
            exp_q.push_back(e);
        end else begin
            for (int w = 0; w < wc; w++) begin
                e.kind  = EV_WRITE;
                e.addr  = base + 32'(4 * w);
                e.data  = {stim_bytes[4*w], stim_bytes[4*w+1], stim_bytes[4*w+2], stim_bytes[4*w+3]};
                e.words = 0;
                exp_q.push_back(e);
            end
            e.kind = EV_DONE; e.addr = 0; e.data = 0; e.words = wc;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        ev_t      e;
        ev_kind_t seen;
        forever begin
            @(negedge CLK);
            if (!Reset && (WrEn || Done || Err)) begin
                seen = WrEn ? EV_WRITE : (Done ? EV_DONE : EV_ERR);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_event: got kind %0d, want none", seen);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_kind", 32'(seen), 32'(e.kind));
                    if (seen == EV_WRITE && e.kind == EV_WRITE) begin
                        checkOutput("wr_addr", WrAddr, e.addr);
                        checkOutput("wr_data", WrData, e.data);
                        checkOutput("ready_in_write", 32'(ByteReady), 32'd0);
                        checkOutput("busy_in_write", 32'(Busy), 32'd1);
                    end else if (seen == EV_DONE && e.kind == EV_DONE) begin
                        checkOutput("busy_in_done", 32'(Busy), 32'd1);
                        if (e.words > 0)
                            checkOutput("done_after_wr", 32'(cyc - last_wr_cyc), 32'd1);
                    end else if (seen == EV_ERR && e.kind == EV_ERR) begin
                        checkOutput("busy_on_err", 32'(Busy), 32'd0);
                    end
                end
                if (seen == EV_WRITE) begin
                    prev_wr_cyc = last_wr_cyc;
                    last_wr_cyc = cyc;
                end else begin
                    ends_seen++;
                end
            end
        end
    end

    // Starts a session, streams its bytes with optional gaps, and waits for
    // it to finish. inject_at >= 0 pulses a stray Start at that byte index.
    task automatic applyStimulus(input logic [31:0] base, input int wc, input int gap_pct,
                                 input bit toggle, input int inject_at);
        int  nbytes;
        int  guard;
        int  start_ends;
        bit  held;
        bit  phase;
        bit  injected;
        bit  ok;
        ok = !((base % 4) != 0 || longint'(base) + 4 * longint'(wc) > MEM_BYTES);
        nbytes = ok ? 4 * wc : 0;
        if (stim_bytes.size() == 0)
            for (int i = 0; i < nbytes; i++) stim_bytes.push_back(8'($urandom));
        modelSession(base, wc);
        start_ends = ends_seen;
        @(negedge CLK);
        Start = 1'b1; BaseAddr = base; WordCount = CNT_W'(wc);
        @(negedge CLK);
        Start = 1'b0;
        held = 0; phase = 1; injected = 0; guard = 0;
        for (int i = 0; i < nbytes; ) begin
            if (toggle) ByteValid = phase;
            else if (held) ByteValid = 1'b1;
            else ByteValid = ($urandom_range(99) >= gap_pct);
            phase = ~phase;
            ByteIn = ByteValid ? stim_bytes[i] : 8'($urandom);
            Start = 1'b0;
            if (i == inject_at && !injected) begin
                Start = 1'b1; BaseAddr = 32'd100; WordCount = CNT_W'(1);
                injected = 1;
            end
            held = ByteValid && !ByteReady;
            if (ByteValid && ByteReady) i++;
            @(negedge CLK);
            guard++;
            if (guard > 500) begin
                compared++; mismatched++;
                $display("[TB] FAIL byte_accept_timeout: got %0d bytes, want %0d", i, nbytes);
                break;
            end
        end
        ByteValid = 1'b0; Start = 1'b0;
        guard = 0;
        while (ends_seen == start_ends && guard < 60) begin
            @(negedge CLK);
            guard++;
        end
        if (ends_seen == start_ends) begin
            compared++; mismatched++;
            $display("[TB] FAIL session_end_timeout: got no Done/Err, want one");
        end
        @(negedge CLK);
        checkOutput("busy_after_end", 32'(Busy), 32'd0);
        checkOutput("ready_after_end", 32'(ByteReady), 32'd0);
        stim_bytes.delete();
    endtask

    initial begin
        logic [31:0] rb;
        int          rw;
        compared = 0; mismatched = 0; cyc = 0;
        last_wr_cyc = 0; prev_wr_cyc = 0; ends_seen = 0;
        Reset = 1'b1; Start = 1'b0; BaseAddr = '0; WordCount = '0;
        ByteIn = '0; ByteValid = 1'b0;
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        checkOutput("rst_ready", 32'(ByteReady), 32'd0);
        checkOutput("rst_wren", 32'(WrEn), 32'd0);
        checkOutput("rst_wraddr", WrAddr, 32'd0);
        checkOutput("rst_wrdata", WrData, 32'd0);
        checkOutput("rst_busy", 32'(Busy), 32'd0);
        checkOutput("rst_done", 32'(Done), 32'd0);
        checkOutput("rst_err", 32'(Err), 32'd0);

        $display("[TB] two-word load at full rate");
        stim_bytes = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04};
        applyStimulus(32'd0, 2, 0, 1'b0, -1);
        checkOutput("wr_spacing", 32'(last_wr_cyc - prev_wr_cyc), 32'd5);

        $display("[TB] alternating valid");
        stim_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus(32'd40, 1, 0, 1'b1, -1);

        $display("[TB] rejections and top-of-memory load");
        applyStimulus(32'd2, 1, 0, 1'b0, -1);
        applyStimulus(32'd236, 2, 0, 1'b0, -1);
        applyStimulus(32'd236, 1, 20, 1'b0, -1);
        applyStimulus(32'd0, 32'hFFFF, 0, 1'b0, -1);

        $display("[TB] zero-length session");
        applyStimulus(32'd0, 0, 0, 1'b0, -1);

        $display("[TB] reset in the middle of a word");
        @(negedge CLK);
        Start = 1'b1; BaseAddr = 32'd0; WordCount = CNT_W'(1);
        @(negedge CLK);
        Start = 1'b0;
        ByteValid = 1'b1; ByteIn = 8'hAA;
        @(negedge CLK);
        ByteIn = 8'hBB;
        @(negedge CLK);
        ByteValid = 1'b0; Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        checkOutput("midrst_ready", 32'(ByteReady), 32'd0);
        checkOutput("midrst_busy", 32'(Busy), 32'd0);
        checkOutput("midrst_wraddr", WrAddr, 32'd0);
        checkOutput("midrst_wrdata", WrData, 32'd0);
        stim_bytes = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        applyStimulus(32'd8, 1, 0, 1'b0, -1);

        $display("[TB] stray Start during a session");
        applyStimulus(32'd16, 3, 25, 1'b0, 5);

        $display("[TB] randomized sessions");
        for (int s = 0; s < 25; s++) begin
            case ($urandom_range(9))
                0:       begin rb = 32'($urandom_range(59) * 4 + $urandom_range(3) + 1); rw = 1; end
                1:       begin rb = 32'($urandom_range(59) * 4); rw = 60; end
                default: begin rb = 32'($urandom_range(55) * 4); rw = $urandom_range(4); end
            endcase
            applyStimulus(rb, rw, $urandom_range(50), 1'b0, -1);
        end

        repeat (5) @(negedge CLK);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ins_mem_loader.md
Name: ins_mem_loader

Overview:
- Write-side counterpart to the instruction memory fetch port.
- Accepts a byte stream over a valid/ready handshake and packs each group of 4 bytes into a big-endian 32-bit word: first byte goes to [31:24] at Addr+0, last byte to [7:0] at Addr+3.
- Issues one word write per 4 bytes into the instruction RAM.
- Holds the CPU via Busy while a program image is loaded at a given base address.

Parameters:
- MEM_BYTES, 240: instruction RAM size in bytes. Valid byte addresses are 0..MEM_BYTES-1.
- CNT_W, 16: width of WordCount.

Ports:
- CLK  in  1  clock. All state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle request to begin a load session. Sampled only in IDLE.
- BaseAddr  in  32  byte address of the first word. Must be a multiple of 4.
- WordCount  in  CNT_W  number of 32-bit words to load.
- ByteIn  in  8  stream byte.
- ByteValid  in  1  ByteIn is valid.
- ByteReady  out  1  loader accepts ByteIn this cycle.
- WrEn  out  1  one-cycle word write strobe to the instruction RAM.
- WrAddr  out  32  byte address of the word being written.
- WrData  out  32  big-endian word. Memory side stores ram[WrAddr]=WrData[31:24] … ram[WrAddr+3]=WrData[7:0].
- Busy  out  1  session in progress. Drives the CPU hold.
- Done  out  1  one-cycle pulse when a session completes.
- Err  out  1  one-cycle pulse when Start is rejected.

Behaviour:
- Reset values: ByteReady=0, WrEn=0, WrAddr=0, WrData=0, Busy=0, Done=0, Err=0. State=IDLE, byte counter=0, assembly register=0.
- All outputs are registered. A byte transfer occurs only on a cycle where ByteValid=1 and ByteReady=1.
- IDLE:
  - Start=1 with BaseAddr[1:0]!=0, or BaseAddr+4*WordCount > MEM_BYTES (computed at 33+ bits, no wrap): Err=1 next cycle, stay in IDLE.
  - Start=1 with WordCount=0 and BaseAddr aligned: go to DONE. No write is issued.
  - Start=1, otherwise: latch the address and remaining count, Busy=1, go to COLLECT.
  - Start=0: stay in IDLE.
- COLLECT:
  - ByteReady=1.
  - Each transfer: assembly <= {assembly[23:0], ByteIn}, byte counter +1.
  - On the 4th transfer: counter wraps to 0, WrData <= assembled word, WrAddr <= current address, WrEn=1 next cycle, go to WRITE.
  - ByteValid=0 stalls indefinitely with no timeout.
- WRITE (exactly one cycle):
  - WrEn=1 and ByteReady=0.
  - Address +4, remaining count -1.
  - Remaining count reaches 0: go to DONE. Otherwise return to COLLECT.
- DONE (one cycle): Done=1, Busy=0 on exit, go to IDLE. No WrEn in this cycle.
- Throughput: at most 1 word per 5 cycles (4 byte cycles + 1 write cycle). The last WrEn is followed by Done on the next cycle.
- Busy is 1 from the cycle after an accepted Start through the DONE cycle inclusive.
- Start while Busy is ignored, with no Err.
- ByteValid while not ByteReady: the byte is not consumed, and the source must hold it.
- Reset mid-session: return to IDLE next cycle. A partial word is discarded and no WrEn is issued. Words already written remain in the RAM.
- WrAddr and WrData hold their last values when WrEn=0.

Decomposition:
- Shared package ins_mem_pkg contains:
  - state encoding: IDLE, COLLECT, WRITE, DONE;
  - BYTES_PER_WORD=4;
  - default MEM_BYTES=240.
- Sub-module word_assembler holds the 8→32 shift register and the 2-bit byte counter. It has inputs shift_en and clear, and outputs word and last_byte.
- The FSM, address/count registers and bounds check stay in ins_mem_loader.

Test Plan:
- Load 2 words: BaseAddr=0, WordCount=2, stream 20 01 00 05 / 8C 22 00 04 with ByteValid held high → WrEn at (0,32'h20010005) then (4,32'h8C220004), 5 cycles apart. Done 1 cycle after the 2nd WrEn. Busy high throughout.
- Backpressure and gaps: ByteValid toggled 1-0-1-0 across the 4 bytes 11 22 33 44 → one WrEn with WrData=32'h11223344. No byte lost or duplicated. ByteReady=0 during WRITE.
- Rejection: BaseAddr=2 → Err pulse, Busy stays 0. BaseAddr=236, WordCount=2 → Err. BaseAddr=236, WordCount=1 → accepted, single write at 236.
- Zero-length: WordCount=0, BaseAddr=0 → Done pulse with no WrEn, Busy=1 only in the DONE cycle.
- Reset mid-word: after 2 of 4 bytes, Reset=1 for 1 cycle → IDLE with all outputs 0 and no WrEn. A new session at BaseAddr=8 with 4 bytes writes the full new word, with no stale byte left from the discarded partial word.
- Start during Busy: a second Start with a different BaseAddr mid-session → ignored, no Err, the original session completes unchanged.
